// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready front end for a combinational ALU, with an exhaustive hardware sweep mode
module alu_cmd_sequencer #(
  parameter int DATA_W      = 8,
  parameter int CMD_W       = 4,
  parameter int SETTLE      = 1,
  parameter int SWEEP_LIMIT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  input  logic [CMD_W-1:0]    req_cmd,
  input  logic                sweep_start,
  input  logic                sweep_abort,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [CMD_W-1:0]    alu_cmd,
  output logic                alu_oe,
  input  logic [2*DATA_W-1:0] alu_y,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_a,
  output logic [DATA_W-1:0]   rsp_b,
  output logic [CMD_W-1:0]    rsp_cmd,
  output logic [2*DATA_W-1:0] rsp_y,
  output logic                busy,
  output logic                sweep_done
);
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [DATA_W-1:0] LAST = DATA_W'(SWEEP_LIMIT - 1);
  localparam logic [SW-1:0] SEND = SW'(SETTLE - 1);
  state_t state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
  logic [CMD_W-1:0] alu_cmd_q, alu_cmd_d, rsp_cmd_q, rsp_cmd_d;
  logic [2*DATA_W-1:0] rsp_y_q, rsp_y_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic alu_oe_q, alu_oe_d, rsp_valid_q, rsp_valid_d, sweep_q, sweep_d;
  logic abort_q, abort_d, done_q, done_d, hs, last, stop;
  // The alu_* registers double as the sweep counters
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cmd_d   = alu_cmd_q;
    alu_oe_d    = alu_oe_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    rsp_cmd_d   = rsp_cmd_q;
    rsp_y_d     = rsp_y_q;
    rsp_valid_d = rsp_valid_q;
    cnt_d       = cnt_q;
    sweep_d     = sweep_q;
    abort_d     = abort_q;
    done_d      = 1'b0;
    hs          = rsp_valid_q & rsp_ready;
    last        = alu_a_q == LAST && alu_b_q == LAST && &alu_cmd_q;
    stop        = 1'b0;
    case (state_q)
      IDLE: begin
        alu_oe_d = 1'b0;
        abort_d  = 1'b0;
        cnt_d    = '0;
        if (sweep_start) begin
          sweep_d   = 1'b1;
          alu_a_d   = '0;
          alu_b_d   = '0;
          alu_cmd_d = '0;
          alu_oe_d  = 1'b1;
          state_d   = DRIVE;
        end else if (req_valid) begin
          alu_a_d   = req_a;
          alu_b_d   = req_b;
          alu_cmd_d = req_cmd;
          alu_oe_d  = 1'b1;
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        abort_d = abort_q | (sweep_q & sweep_abort);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == SEND) begin
          rsp_a_d     = alu_a_q;
          rsp_b_d     = alu_b_q;
          rsp_cmd_d   = alu_cmd_q;
          rsp_y_d     = alu_y;
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = RESP;
        end
      end
      RESP: begin
        abort_d = abort_q | (sweep_q & sweep_abort);
        if (hs) begin
          rsp_valid_d = 1'b0;
          stop        = !sweep_q || abort_d || last;
          if (stop) begin
            done_d   = sweep_q & !abort_d;
            state_d  = IDLE;
            alu_oe_d = 1'b0;
            sweep_d  = 1'b0;
            abort_d  = 1'b0;
          end else begin
            alu_cmd_d = alu_cmd_q + 1'b1;
            alu_b_d   = &alu_cmd_q ? (alu_b_q == LAST ? '0 : alu_b_q + 1'b1) : alu_b_q;
            alu_a_d   = &alu_cmd_q && alu_b_q == LAST ? alu_a_q + 1'b1 : alu_a_q;
            state_d   = DRIVE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cmd_q   <= '0;
      alu_oe_q    <= 1'b0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      rsp_cmd_q   <= '0;
      rsp_y_q     <= '0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
      sweep_q     <= 1'b0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cmd_q   <= alu_cmd_d;
      alu_oe_q    <= alu_oe_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      rsp_cmd_q   <= rsp_cmd_d;
      rsp_y_q     <= rsp_y_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
      sweep_q     <= sweep_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
    end
  end
  assign req_ready  = state_q == IDLE && !sweep_start;
  assign busy       = state_q != IDLE;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cmd    = alu_cmd_q;
  assign alu_oe     = alu_oe_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_a      = rsp_a_q;
  assign rsp_b      = rsp_b_q;
  assign rsp_cmd    = rsp_cmd_q;
  assign rsp_y      = rsp_y_q;
  assign sweep_done = done_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: vector table plus scoreboarded sweep, abort, backpressure and reset sequences
module tb_alu_cmd_sequencer;
  localparam int DW = 8, CW = 4, SL = 2, NC = 16;
  logic clk = 0, rst_n = 0, req_valid = 0, req_ready, sweep_start = 0, sweep_abort = 0;
  logic [DW-1:0] req_a = 0, req_b = 0, alu_a, alu_b, rsp_a, rsp_b;
  logic [CW-1:0] req_cmd = 0, alu_cmd, rsp_cmd;
  logic alu_oe, rsp_valid, rsp_ready = 1, busy, sweep_done;
  logic [2*DW-1:0] alu_y, rsp_y;
  typedef struct packed {logic [7:0] a, b; logic [3:0] c; logic [15:0] y;} rec_t;
  typedef struct {logic [7:0] a, b; logic [3:0] c; logic [15:0] y;} vec_t;
  rec_t q[$];
  rec_t e;
  vec_t tv[7];
  int checks = 0, errors = 0, rsp_cnt = 0, done_cnt = 0, cyc = 0, last_hs = -10, n, dc;

  alu_cmd_sequencer #(.DATA_W(DW), .CMD_W(CW), .SETTLE(1), .SWEEP_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd), .sweep_start(sweep_start),
    .sweep_abort(sweep_abort), .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_oe(alu_oe), .alu_y(alu_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_cmd(rsp_cmd), .rsp_y(rsp_y), .busy(busy),
    .sweep_done(sweep_done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] alu_f(input logic [7:0] a, b, input logic [3:0] c);
    case (c)
      4'd0:    return {8'b0, a} + {8'b0, b};
      4'd1:    return {8'b0, a - b};
      4'd2:    return {8'b0, a} * {8'b0, b};
      4'd3:    return {8'b0, a & b};
      4'd4:    return {8'b0, a | b};
      4'd5:    return {8'b0, a ^ b};
      4'd15:   return {8'b0, a};
      default: return {a, b ^ {4'b0, c}};
    endcase
  endfunction
  assign alu_y = alu_oe ? alu_f(alu_a, alu_b, alu_cmd) : 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_rst(input string name);
    chk({name, "_outs"}, {alu_a, alu_b, alu_cmd, alu_oe, rsp_valid, rsp_a, rsp_b, rsp_cmd, rsp_y, busy, sweep_done}, 0);
    chk({name, "_req_ready"}, req_ready, 1);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual=%0h required=none", {rsp_a, rsp_b, rsp_cmd, rsp_y});
      end else begin
        e = q.pop_front();
        chk("rsp", {rsp_a, rsp_b, rsp_cmd, rsp_y}, e);
      end
      rsp_cnt++;
      last_hs = cyc;
    end
    if (sweep_done) begin
      done_cnt++;
      chk("done_timing", cyc, last_hs + 1);
    end
  end

  task automatic wait_rsp(input int target, input int budget);
    int t = 0;
    while (rsp_cnt < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("rsp_timeout", rsp_cnt >= target, 1);
  endtask

  task automatic send(input logic [7:0] a, b, input logic [3:0] c, input logic [15:0] y, input bit push);
    int t = 0;
    while (!req_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("req_ready_timeout", req_ready, 1);
    req_a = a; req_b = b; req_cmd = c; req_valid = 1;
    if (push) q.push_back(rec_t'({a, b, c, y}));
    @(posedge clk); #1;
    req_valid = 0;
    req_a = 8'($urandom); req_b = 8'($urandom); req_cmd = 4'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{8'd20, 8'd10, 4'd0, 16'd30};
    tv[1] = '{8'd255, 8'd1, 4'd0, 16'd256};
    tv[2] = '{8'd25, 8'd17, 4'd1, 16'd8};
    tv[3] = '{8'd15, 8'd15, 4'd2, 16'd225};
    tv[4] = '{8'd255, 8'd255, 4'd2, 16'd65025};
    tv[5] = '{8'hF0, 8'h3C, 4'd3, 16'h0030};
    tv[6] = '{8'h5A, 8'h11, 4'd15, 16'h005A};
    repeat (2) @(posedge clk); #1;
    chk_rst("reset");
    rst_n = 1;
    @(posedge clk); #1;
    send(8'd20, 8'd10, 4'd0, 16'd30, 1);
    chk("add_drive_valid", rsp_valid, 0);
    chk("add_drive_busy", busy, 1);
    chk("add_drive_oe", alu_oe, 1);
    @(posedge clk); #1;
    chk("add_rsp_valid", rsp_valid, 1);
    chk("add_rsp_y", rsp_y, 16'd30);
    @(posedge clk); #1;
    chk("add_busy_fall", busy, 0);
    chk("add_req_ready", req_ready, 1);
    n = rsp_cnt;
    for (int i = 0; i < 7; i++) send(tv[i].a, tv[i].b, tv[i].c, tv[i].y, 1);
    wait_rsp(n + 7, 50);
    @(posedge clk); #1;
    chk("table_drained", q.size(), 0);
    rsp_ready = 0;
    send(8'd25, 8'd17, 4'd1, 16'd8, 1);
    n = rsp_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_hold", {rsp_a, rsp_b, rsp_cmd, rsp_y}, {8'd25, 8'd17, 4'd1, 16'd8});
      chk("bp_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("bp_single_hs", rsp_cnt, n + 1);
    chk("bp_valid_low", rsp_valid, 0);
    n = rsp_cnt; dc = done_cnt;
    req_a = 8'd99; req_b = 8'd1; req_cmd = 4'd0; req_valid = 1; sweep_start = 1;
    #1 chk("sweep_prio_ready", req_ready, 0);
    for (int a = 0; a < SL; a++)
      for (int b = 0; b < SL; b++)
        for (int c = 0; c < NC; c++)
          q.push_back(rec_t'({8'(a), 8'(b), 4'(c), alu_f(8'(a), 8'(b), 4'(c))}));
    @(posedge clk); #1;
    sweep_start = 0; req_valid = 0;
    chk("sweep_busy", busy, 1);
    chk("sweep_oe", alu_oe, 1);
    wait_rsp(n + SL * SL * NC, 400);
    repeat (4) @(posedge clk); #1;
    chk("sweep_count", rsp_cnt, n + SL * SL * NC);
    chk("sweep_done_once", done_cnt, dc + 1);
    chk("sweep_idle", busy, 0);
    chk("sweep_oe_off", alu_oe, 0);
    chk("sweep_drained", q.size(), 0);
    n = rsp_cnt; dc = done_cnt;
    sweep_start = 1;
    for (int c = 0; c < 5; c++) q.push_back(rec_t'({8'd0, 8'd0, 4'(c), alu_f(8'd0, 8'd0, 4'(c))}));
    @(posedge clk); #1;
    sweep_start = 0;
    wait_rsp(n + 4, 100);
    @(posedge clk); #1;
    sweep_abort = 1;
    wait_rsp(n + 5, 100);
    @(posedge clk); #1;
    sweep_abort = 0;
    repeat (4) @(posedge clk); #1;
    chk("abort_count", rsp_cnt, n + 5);
    chk("abort_idle", busy, 0);
    chk("abort_oe", alu_oe, 0);
    chk("abort_no_done", done_cnt, dc);
    chk("abort_drained", q.size(), 0);
    n = rsp_cnt;
    send(8'd15, 8'd15, 4'd2, 16'd225, 0);
    chk("midrst_busy", busy, 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk_rst("midrst");
    rst_n = 1;
    repeat (5) @(posedge clk); #1;
    chk("midrst_no_rsp", rsp_cnt, n);
    chk("midrst_idle", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
